// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver, oversampled by the system clock, each bit
// sampled at its centre.
// Ports:
//   clk   - system clock, rising edge
//   rstn  - synchronous reset, active-high (1 = reset)
//   rxd   - asynchronous serial input, idles high
//   done  - one-cycle strobe, a freshly received byte is on data
//   data  - last correctly framed byte, bit0 = first data bit on the line
module uart_rx_core #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic       done,
  output logic [7:0] data
);

  localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CYC - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic             start_edge;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic [7:0]       data_nxt;
  logic             done_nxt;

  // Two-flop synchroniser plus a history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Only a high-to-low transition starts a frame, so a held-low break is ignored.
  assign start_edge = rx_prev & ~rx_s;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      data  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      data  <= data_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state and datapath update; IDLE is re-entered at the stop-bit centre
  // so a following start bit can be caught without an idle bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = data;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start_edge) begin
          state_nxt = START;
        end
      end

      START: begin
        if (cnt == CNT_HALF_END) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          // A line back high at mid start bit was a glitch.
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == CNT_BIT_END) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == CNT_BIT_END) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          // A low stop bit is a framing error: the byte is dropped silently.
          if (rx_s) begin
            data_nxt = shift;
            done_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomized frames against a byte-level model
// of the receiver (expected byte list, last-good-byte register, latency window).
module tb_uart_rx_core;

  // A faster line rate keeps the run short; 50e6/1.7e6 also truncates.
  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 1_700_000;
  localparam int unsigned BIT      = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = BIT / 2;
  // done arrives 9.5 bit times after the start edge plus synchroniser delay.
  localparam int unsigned LAT_LO   = 9 * BIT + HALF + 2;
  localparam int unsigned LAT_HI   = 9 * BIT + HALF + 4;

  logic       clk;
  logic       rstn;
  logic       rxd;
  logic       done;
  logic [7:0] data;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned cyc;

  logic [7:0]  exp_q[$];
  int unsigned start_q[$];
  logic [7:0]  got_q[$];
  int unsigned done_cyc_q[$];
  logic [7:0]  exp_data;
  logic        prev_done;
  logic        dbl_done;

  uart_rx_core #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .rxd (rxd),
    .done(done),
    .data(data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every done strobe and flag back-to-back strobes.
  always @(negedge clk) begin
    if (done) begin
      got_q.push_back(data);
      done_cyc_q.push_back(cyc);
    end
    if (done && prev_done) dbl_done <= 1'b1;
    prev_done <= done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; holds rxd for one bit time.
  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle_bits(input int unsigned n);
    for (int i = 0; i < int'(n); i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int unsigned gap);
    int unsigned s;
    s = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (stop_ok) begin
      exp_q.push_back(b);
      start_q.push_back(s);
      exp_data = b;
    end
    idle_bits(gap);
  endtask

  task automatic check_section(input string tag);
    int n;
    int unsigned lat;
    check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      lat = done_cyc_q[i] - start_q[i];
      check($sformatf("%s latency%0d", tag, i),
            32'((lat >= LAT_LO) && (lat <= LAT_HI)), 32'd1);
    end
    check({tag, " data"}, 32'(data), 32'(exp_data));
    check({tag, " done idle"}, 32'(done), 32'd0);
    got_q.delete();
    done_cyc_q.delete();
    exp_q.delete();
    start_q.delete();
  endtask

  initial begin
    logic [7:0]  rb;
    logic        rok;
    int unsigned rgap;

    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    exp_data    = 8'h00;
    prev_done   = 1'b0;
    dbl_done    = 1'b0;
    rxd         = 1'b1;
    rstn        = 1'b1;

    repeat (5) @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset done", 32'(done), 32'd0);
    check("reset data", 32'(data), 32'h00);

    // Single frame.
    send_frame(8'h22, 1'b1, 2);
    check_section("t1");

    // Frames separated by long idle gaps.
    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h33, 1'b1, 10);
    send_frame(8'h34, 1'b1, 10);
    check_section("t2");

    // Back-to-back frames, no idle bit between them.
    send_frame(8'hA5, 1'b1, 0);
    send_frame(8'h5A, 1'b1, 2);
    check_section("t3");

    // Short low glitch on an idle line, then a real frame.
    rxd = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    idle_bits(3);
    check_section("t4 glitch");
    send_frame(8'h3C, 1'b1, 2);
    check_section("t4");

    // Framing error followed by a held-low break, then recovery.
    send_frame(8'hFF, 1'b0, 0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    check_section("t5 break");
    idle_bits(2);
    send_frame(8'h01, 1'b1, 2);
    check_section("t5");

    // Reset in the middle of data bit 4.
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
    rxd = 1'b0;
    repeat (HALF) @(negedge clk);
    rstn = 1'b1;
    rxd  = 1'b1;
    repeat (3) @(negedge clk);
    check("t6 reset done", 32'(done), 32'd0);
    check("t6 reset data", 32'(data), 32'h00);
    rstn = 1'b0;
    exp_data = 8'h00;
    idle_bits(12);
    check_section("t6 abort");
    send_frame(8'h80, 1'b1, 2);
    check_section("t6");

    // Randomized frames; a bad stop bit is always followed by an idle bit.
    for (int k = 0; k < 6; k++) begin
      rb   = 8'($urandom);
      rok  = ($urandom_range(0, 3) != 0);
      rgap = rok ? $urandom_range(0, 1) : 1 + $urandom_range(0, 1);
      send_frame(rb, rok, rgap);
    end
    idle_bits(2);
    check_section("rand");

    check("no double done", 32'(dbl_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
